// File: rtl/game_pkg.sv
// Shared encodings and helpers for the two-player memory game turn controller.
package game_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_CLR1    = 3'd1,
        ST_P1_TURN = 3'd2,
        ST_CLR2    = 3'd3,
        ST_P2_TURN = 3'd4,
        ST_DONE    = 3'd5
    } state_e;

    localparam logic [1:0] TURN_NONE = 2'b00;
    localparam logic [1:0] TURN_P1   = 2'b01;
    localparam logic [1:0] TURN_P2   = 2'b10;

    localparam logic [1:0] WIN_NONE  = 2'b00;
    localparam logic [1:0] WIN_P1    = 2'b01;
    localparam logic [1:0] WIN_P2    = 2'b10;
    localparam logic [1:0] WIN_TIE   = 2'b11;

    localparam logic [2:0] SCORE_MAX = 3'd7;

    function automatic logic [2:0] sat_inc3(input logic [2:0] v);
        if (v == SCORE_MAX) begin
            return SCORE_MAX;
        end else begin
            return v + 3'd1;
        end
    endfunction

    function automatic logic [1:0] win_code(input logic [2:0] s1, input logic [2:0] s2);
        if (s1 > s2) begin
            return WIN_P1;
        end else if (s2 > s1) begin
            return WIN_P2;
        end else begin
            return WIN_TIE;
        end
    endfunction

endpackage

// File: rtl/game_turn_ctrl_if.sv
// Player/compare-logic and Timer1s side of the turn controller.
// master = surrounding game logic, slave = game_turn_ctrl.
interface game_turn_ctrl_if #(
    parameter int TW = 11
);
    logic          Begin;
    logic          P1_Done;
    logic          P1_Match;
    logic          P2_Done;
    logic          P2_Match;
    logic [TW-1:0] Timer_Out;
    logic          Timer_Start;
    logic [1:0]    Turn;
    logic [2:0]    P1_Score;
    logic [2:0]    P2_Score;
    logic [2:0]    Round;
    logic          Timeout;
    logic          Game_Over;
    logic [1:0]    Winner;

    modport master (
        output Begin, P1_Done, P1_Match, P2_Done, P2_Match, Timer_Out,
        input  Timer_Start, Turn, P1_Score, P2_Score, Round, Timeout, Game_Over, Winner
    );

    modport slave (
        input  Begin, P1_Done, P1_Match, P2_Done, P2_Match, Timer_Out,
        output Timer_Start, Turn, P1_Score, P2_Score, Round, Timeout, Game_Over, Winner
    );
endinterface

// File: rtl/score_counter.sv
// 3-bit saturating score counter; clear has priority over increment.
module score_counter
    import game_pkg::*;
(
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       clr_i,
    input  logic       inc_i,
    output logic [2:0] cnt_o
);

    logic [2:0] cnt_q;
    logic [2:0] cnt_d;

    // next count: clear, saturating increment or hold
    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = 3'd0;
        end else if (inc_i) begin
            cnt_d = sat_inc3(cnt_q);
        end else begin
            cnt_d = cnt_q;
        end
    end

    // count register
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= 3'd0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/game_turn_ctrl.sv
// Round/turn controller: allocates the shared seconds timer to one player at a
// time, closes turns on submission or timeout, keeps scores and rounds, declares the winner.
module game_turn_ctrl
    import game_pkg::*;
#(
    parameter int TURN_LIMIT = 10,
    parameter int TW         = 11,
    parameter int ROUNDS     = 4
) (
    input logic             Clk,
    input logic             Rst,
    game_turn_ctrl_if.slave bus
);

    localparam logic [TW-1:0] LIMIT      = TW'(TURN_LIMIT);
    localparam logic [2:0]    LAST_ROUND = 3'(ROUNDS);

    state_e     state_q, state_d;
    logic [2:0] round_q, round_d;
    logic       tstart_q, tstart_d;
    logic       timeout_q, timeout_d;
    logic       over_q, over_d;
    logic [1:0] turn_q, turn_d;
    logic [1:0] winner_q, winner_d;

    logic       score_clr_s;
    logic       p1_inc_s;
    logic       p2_inc_s;
    logic       expired_s;
    logic [2:0] p1_score_s;
    logic [2:0] p2_score_s;
    logic [2:0] p2_next_s;

    assign expired_s = (bus.Timer_Out >= LIMIT);

    // next state and registered-output values; a Done always beats a same-cycle timeout
    always_comb begin
        state_d     = state_q;
        round_d     = round_q;
        tstart_d    = 1'b0;
        timeout_d   = 1'b0;
        over_d      = 1'b0;
        turn_d      = TURN_NONE;
        winner_d    = WIN_NONE;
        score_clr_s = 1'b0;
        p1_inc_s    = 1'b0;
        p2_inc_s    = 1'b0;
        p2_next_s   = p2_score_s;
        case (state_q)
            ST_IDLE: begin
                if (bus.Begin) begin
                    score_clr_s = 1'b1;
                    round_d     = 3'd1;
                    state_d     = ST_CLR1;
                end else begin
                    state_d     = ST_IDLE;
                end
            end
            ST_CLR1: begin
                state_d  = ST_P1_TURN;
                tstart_d = 1'b1;
                turn_d   = TURN_P1;
            end
            ST_P1_TURN: begin
                if (bus.P1_Done || expired_s) begin
                    p1_inc_s  = bus.P1_Done & bus.P1_Match;
                    timeout_d = ~bus.P1_Done;
                    state_d   = ST_CLR2;
                end else begin
                    tstart_d  = 1'b1;
                    turn_d    = TURN_P1;
                end
            end
            ST_CLR2: begin
                state_d  = ST_P2_TURN;
                tstart_d = 1'b1;
                turn_d   = TURN_P2;
            end
            ST_P2_TURN: begin
                if (bus.P2_Done || expired_s) begin
                    p2_inc_s  = bus.P2_Done & bus.P2_Match;
                    timeout_d = ~bus.P2_Done;
                    p2_next_s = p2_inc_s ? sat_inc3(p2_score_s) : p2_score_s;
                    if (round_q == LAST_ROUND) begin
                        // winner must see the final P2 update landing on this same edge
                        state_d  = ST_DONE;
                        over_d   = 1'b1;
                        winner_d = win_code(p1_score_s, p2_next_s);
                    end else begin
                        round_d  = round_q + 3'd1;
                        state_d  = ST_CLR1;
                    end
                end else begin
                    tstart_d = 1'b1;
                    turn_d   = TURN_P2;
                end
            end
            ST_DONE: begin
                if (bus.Begin) begin
                    score_clr_s = 1'b1;
                    round_d     = 3'd1;
                    state_d     = ST_CLR1;
                end else begin
                    over_d      = 1'b1;
                    winner_d    = winner_q;
                end
            end
            default: begin
                state_d = ST_IDLE;
                round_d = 3'd0;
            end
        endcase
    end

    // state and output registers
    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            state_q   <= ST_IDLE;
            round_q   <= 3'd0;
            tstart_q  <= 1'b0;
            timeout_q <= 1'b0;
            over_q    <= 1'b0;
            turn_q    <= TURN_NONE;
            winner_q  <= WIN_NONE;
        end else begin
            state_q   <= state_d;
            round_q   <= round_d;
            tstart_q  <= tstart_d;
            timeout_q <= timeout_d;
            over_q    <= over_d;
            turn_q    <= turn_d;
            winner_q  <= winner_d;
        end
    end

    score_counter u_p1_score (
        .clk_i  (Clk),
        .rst_ni (Rst),
        .clr_i  (score_clr_s),
        .inc_i  (p1_inc_s),
        .cnt_o  (p1_score_s)
    );

    score_counter u_p2_score (
        .clk_i  (Clk),
        .rst_ni (Rst),
        .clr_i  (score_clr_s),
        .inc_i  (p2_inc_s),
        .cnt_o  (p2_score_s)
    );

    assign bus.Timer_Start = tstart_q;
    assign bus.Turn        = turn_q;
    assign bus.P1_Score    = p1_score_s;
    assign bus.P2_Score    = p2_score_s;
    assign bus.Round       = round_q;
    assign bus.Timeout     = timeout_q;
    assign bus.Game_Over   = over_q;
    assign bus.Winner      = winner_q;

endmodule

// File: tb/tb_game_turn_ctrl.sv
// Self-checking bench for game_turn_ctrl: directed scenarios, a saturation run,
// and randomized play checked every cycle against a turn-level reference model.
module tb_game_turn_ctrl;

    localparam int TL  = 3;
    localparam int RN  = 2;
    localparam int TWB = 11;

    logic Clk = 1'b0;
    logic Rst = 1'b0;
    always #5 Clk = ~Clk;

    int n_chk  = 0;
    int n_pass = 0;

    game_turn_ctrl_if #(.TW(TWB)) bus ();
    game_turn_ctrl #(.TURN_LIMIT(TL), .TW(TWB), .ROUNDS(RN)) dut (
        .Clk (Clk), .Rst (Rst), .bus (bus.slave)
    );

    game_turn_ctrl_if #(.TW(TWB)) bus7 ();
    game_turn_ctrl #(.TURN_LIMIT(TL), .TW(TWB), .ROUNDS(7)) dut7 (
        .Clk (Clk), .Rst (Rst), .bus (bus7.slave)
    );

    logic       sc_clr = 1'b0;
    logic       sc_inc = 1'b0;
    logic [2:0] sc_cnt;
    score_counter sc (
        .clk_i (Clk), .rst_ni (Rst), .clr_i (sc_clr), .inc_i (sc_inc), .cnt_o (sc_cnt)
    );

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act == exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic int sat7(input int v);
        return (v > 7) ? 7 : v;
    endfunction

    function automatic int win_of(input int a, input int b);
        if (a > b) return 1;
        else if (b > a) return 2;
        else return 3;
    endfunction

    // ---------------- reference model: who owns the timer, scores, rounds ----------------
    bit m_idle = 1'b1;
    bit m_over = 1'b0;
    bit m_tout = 1'b0;
    int m_active = 0;   // player currently holding the timer (0 = nobody)
    int m_gap = 0;      // 1 while the timer is being cleared before the next turn
    int m_next = 0;     // player who gets the timer after the clear
    int m_round = 0;
    int m_s1 = 0;
    int m_s2 = 0;
    int m_win = 0;

    always @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            m_idle <= 1'b1; m_over <= 1'b0; m_tout <= 1'b0; m_active <= 0; m_gap <= 0;
            m_next <= 0; m_round <= 0; m_s1 <= 0; m_s2 <= 0; m_win <= 0;
        end else begin
            m_tout <= 1'b0;
            if ((m_idle || m_over) && bus.Begin) begin
                m_idle <= 1'b0; m_over <= 1'b0; m_s1 <= 0; m_s2 <= 0; m_round <= 1;
                m_next <= 1; m_gap <= 1; m_win <= 0;
            end else if (m_gap != 0) begin
                m_gap <= 0;
                m_active <= m_next;
            end else if (m_active == 1) begin
                if (bus.P1_Done || bus.Timer_Out >= TL) begin
                    m_active <= 0; m_next <= 2; m_gap <= 1;
                    m_tout <= !bus.P1_Done;
                    if (bus.P1_Done && bus.P1_Match) m_s1 <= sat7(m_s1 + 1);
                end
            end else if (m_active == 2) begin
                if (bus.P2_Done || bus.Timer_Out >= TL) begin
                    m_active <= 0;
                    m_tout <= !bus.P2_Done;
                    if (bus.P2_Done && bus.P2_Match) m_s2 <= sat7(m_s2 + 1);
                    if (m_round == RN) begin
                        m_over <= 1'b1;
                        m_win  <= win_of(m_s1, sat7(m_s2 + ((bus.P2_Done && bus.P2_Match) ? 1 : 0)));
                    end else begin
                        m_round <= m_round + 1; m_next <= 1; m_gap <= 1;
                    end
                end
            end
        end
    end

    // compare every cycle, away from the active edge
    always @(negedge Clk) begin
        if (Rst) begin
            chk("m_timer_start", int'(bus.Timer_Start), (m_active != 0) ? 1 : 0);
            chk("m_turn",        int'(bus.Turn), m_active);
            chk("m_p1_score",    int'(bus.P1_Score), m_s1);
            chk("m_p2_score",    int'(bus.P2_Score), m_s2);
            chk("m_round",       int'(bus.Round), m_round);
            chk("m_timeout",     int'(bus.Timeout), int'(m_tout));
            chk("m_game_over",   int'(bus.Game_Over), int'(m_over));
            chk("m_winner",      int'(bus.Winner), m_over ? m_win : 0);
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic drive_idle();
        bus.Begin = 1'b0; bus.P1_Done = 1'b0; bus.P1_Match = 1'b0;
        bus.P2_Done = 1'b0; bus.P2_Match = 1'b0; bus.Timer_Out = '0;
        bus7.Begin = 1'b0; bus7.P1_Done = 1'b0; bus7.P1_Match = 1'b0;
        bus7.P2_Done = 1'b0; bus7.P2_Match = 1'b0; bus7.Timer_Out = '0;
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_timer_start"}, int'(bus.Timer_Start), 0);
        chk({tag, "_turn"},        int'(bus.Turn), 0);
        chk({tag, "_p1_score"},    int'(bus.P1_Score), 0);
        chk({tag, "_p2_score"},    int'(bus.P2_Score), 0);
        chk({tag, "_round"},       int'(bus.Round), 0);
        chk({tag, "_timeout"},     int'(bus.Timeout), 0);
        chk({tag, "_game_over"},   int'(bus.Game_Over), 0);
        chk({tag, "_winner"},      int'(bus.Winner), 0);
    endtask

    task automatic wait_turn(input int code);
        int i = 0;
        while (int'(bus.Turn) != code && i < 20) begin
            tick();
            i++;
        end
        chk("wait_turn", int'(bus.Turn), code);
    endtask

    task automatic wait_turn7(input int code);
        int i = 0;
        while (int'(bus7.Turn) != code && i < 20) begin
            tick();
            i++;
        end
        chk("wait_turn7", int'(bus7.Turn), code);
    endtask

    task automatic submit(input int player, input bit match);
        if (player == 1) begin
            bus.P1_Done = 1'b1; bus.P1_Match = match;
        end else begin
            bus.P2_Done = 1'b1; bus.P2_Match = match;
        end
        tick();
        bus.P1_Done = 1'b0; bus.P1_Match = 1'b0; bus.P2_Done = 1'b0; bus.P2_Match = 1'b0;
    endtask

    task automatic begin_game();
        bus.Begin = 1'b1;
        tick();
        bus.Begin = 1'b0;
    endtask

    int tout_cnt;
    int tmr;

    initial begin
        drive_idle();
        Rst = 1'b0;
        repeat (3) @(posedge Clk);
        #1;
        chk_reset_outputs("rst");
        #2 Rst = 1'b1;
        tick();

        // start timing: cycles k, k+1, k+2
        bus.Begin = 1'b1;
        chk("start_k", int'(bus.Timer_Start), 0);
        tick();
        bus.Begin = 1'b0;
        chk("start_k1", int'(bus.Timer_Start), 0);
        chk("round_k1", int'(bus.Round), 1);
        tick();
        chk("start_k2", int'(bus.Timer_Start), 1);
        chk("turn_k2", int'(bus.Turn), 1);
        chk("round_k2", int'(bus.Round), 1);

        // P1 scores, then P2 lets the timer run out
        submit(1, 1'b1);
        chk("p1_after_match", int'(bus.P1_Score), 1);
        chk("turn_after_p1", int'(bus.Turn), 0);
        chk("tstart_after_p1", int'(bus.Timer_Start), 0);
        wait_turn(2);
        tout_cnt = 0;
        for (int t = 1; t <= TL; t++) begin
            bus.Timer_Out = TWB'(t);
            tick();
            if (bus.Timeout) tout_cnt++;
        end
        bus.Timer_Out = '0;
        for (int t = 0; t < 3; t++) begin
            tick();
            if (bus.Timeout) tout_cnt++;
        end
        chk("timeout_pulses", tout_cnt, 1);
        chk("p1_after_tout", int'(bus.P1_Score), 1);
        chk("p2_after_tout", int'(bus.P2_Score), 0);
        chk("round_two", int'(bus.Round), 2);

        // round 2: P1 and P2 both match -> 2/1, P1 wins
        wait_turn(1);
        submit(1, 1'b1);
        wait_turn(2);
        submit(2, 1'b1);
        chk("over_p1win", int'(bus.Game_Over), 1);
        chk("winner_p1", int'(bus.Winner), 1);
        chk("final_p1", int'(bus.P1_Score), 2);
        chk("final_p2", int'(bus.P2_Score), 1);
        repeat (3) tick();
        chk("hold_round", int'(bus.Round), 2);
        chk("hold_winner", int'(bus.Winner), 1);

        // restart from DONE, one match each -> tie
        begin_game();
        chk("restart_round", int'(bus.Round), 1);
        chk("restart_p1", int'(bus.P1_Score), 0);
        chk("restart_over", int'(bus.Game_Over), 0);
        wait_turn(1); submit(1, 1'b1);
        wait_turn(2); submit(2, 1'b0);
        wait_turn(1); submit(1, 1'b0);
        wait_turn(2); submit(2, 1'b1);
        chk("winner_tie", int'(bus.Winner), 3);
        chk("over_tie", int'(bus.Game_Over), 1);

        // inactive Done ignored, Begin ignored mid-turn, Done beats timeout
        begin_game();
        wait_turn(1);
        bus.P2_Done = 1'b1; bus.P2_Match = 1'b1; bus.Begin = 1'b1;
        tick();
        bus.P2_Done = 1'b0; bus.P2_Match = 1'b0; bus.Begin = 1'b0;
        chk("inactive_p2", int'(bus.P2_Score), 0);
        chk("inactive_turn", int'(bus.Turn), 1);
        bus.Timer_Out = TWB'(TL);
        submit(1, 1'b1);
        bus.Timer_Out = '0;
        chk("simul_score", int'(bus.P1_Score), 1);
        chk("simul_no_tout", int'(bus.Timeout), 0);

        // asynchronous reset mid P2 turn with scores 1/0
        wait_turn(2);
        tick();
        #2 Rst = 1'b0;
        #1;
        chk_reset_outputs("async_rst");
        @(posedge Clk);
        #3 Rst = 1'b1;
        tick();
        begin_game();
        chk("post_rst_round", int'(bus.Round), 1);
        chk("post_rst_p1", int'(bus.P1_Score), 0);
        chk("post_rst_p2", int'(bus.P2_Score), 0);
        repeat (4) tick();

        // saturation: seven rounds, P1 matching every turn
        bus7.Begin = 1'b1;
        tick();
        bus7.Begin = 1'b0;
        for (int r = 0; r < 7; r++) begin
            wait_turn7(1);
            bus7.P1_Done = 1'b1; bus7.P1_Match = 1'b1;
            tick();
            bus7.P1_Done = 1'b0; bus7.P1_Match = 1'b0;
            wait_turn7(2);
            bus7.P2_Done = 1'b1;
            tick();
            bus7.P2_Done = 1'b0;
        end
        chk("sat_over", int'(bus7.Game_Over), 1);
        chk("sat_p1", int'(bus7.P1_Score), 7);
        chk("sat_winner", int'(bus7.Winner), 1);
        chk("sat_round", int'(bus7.Round), 7);

        // counter alone: forced increments past 7, then clear priority
        sc_inc = 1'b1;
        repeat (9) tick();
        chk("sc_saturate", int'(sc_cnt), 7);
        sc_clr = 1'b1;
        tick();
        sc_clr = 1'b0;
        chk("sc_clear", int'(sc_cnt), 0);
        tick();
        sc_inc = 1'b0;
        chk("sc_inc_one", int'(sc_cnt), 1);

        // randomized play with an emulated seconds timer
        tmr = 0;
        for (int c = 0; c < 4000; c++) begin
            if ($urandom_range(0, 599) == 0) begin
                #2 Rst = 1'b0;
                #1;
                chk("rand_rst_turn", int'(bus.Turn), 0);
                chk("rand_rst_round", int'(bus.Round), 0);
                @(posedge Clk);
                #3 Rst = 1'b1;
                tmr = 0;
            end
            bus.Begin    = ($urandom_range(0, 7) == 0);
            bus.P1_Done  = ($urandom_range(0, 3) == 0);
            bus.P1_Match = $urandom_range(0, 1) == 1;
            bus.P2_Done  = ($urandom_range(0, 3) == 0);
            bus.P2_Match = $urandom_range(0, 1) == 1;
            if (!bus.Timer_Start) begin
                tmr = 0;
            end else if ($urandom_range(0, 40) == 0) begin
                tmr = 2047;
            end else if ($urandom_range(0, 1) == 0 && tmr < 2047) begin
                tmr = tmr + 1;
            end
            bus.Timer_Out = TWB'(tmr);
            tick();
        end
        drive_idle();
        repeat (2) tick();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
